rr_stream_arbiter: RTL and testbench

//  N-to-1 round-robin merge of val/rdy streams; upstream counterpart of the address-routing demux.

---
 rtl/rr_stream_arbiter.sv | 91 +++++++++
 tb/tb_rr_stream_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// N-to-1 round-robin merge of val/rdy streams into one registered output stage.
// Each accepted message is tagged with its source index in the MSBs of ostream_msg.
module rr_stream_arbiter #(
    parameter int nbits   = 32,
    parameter int ninputs = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ninputs-1:0]                    istream_val,
    input  logic [ninputs-1:0][nbits-1:0]         istream_msg,
    output logic [ninputs-1:0]                    istream_rdy,
    output logic                                  ostream_val,
    output logic [$clog2(ninputs)+nbits-1:0]      ostream_msg,
    input  logic                                  ostream_rdy
);

    localparam int          addr_nbits = $clog2(ninputs);
    localparam int unsigned n_u        = ninputs;

    logic                        out_full;
    logic [addr_nbits+nbits-1:0] out_msg;
    logic [addr_nbits-1:0]       ptr;

    logic                        can_accept;
    logic                        grant_found;
    logic [addr_nbits-1:0]       grant_idx;
    logic [ninputs-1:0]          grant;
    logic                        xfer_in;
    logic                        xfer_out;

    // Index arithmetic modulo ninputs, so non-power-of-2 port counts wrap correctly.
    function automatic logic [addr_nbits-1:0] wrap_add(input logic [addr_nbits-1:0] base,
                                                       input int unsigned         offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= n_u) begin
            sum = sum - n_u;
        end
        return sum[addr_nbits-1:0];
    endfunction

    // Scan from ptr upward; the first valid input after the last winner gets the grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < n_u; k++) begin
            if (!grant_found && istream_val[wrap_add(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        grant            = '0;
        grant[grant_idx] = grant_found;
    end

    // Handshakes are suppressed in a reset cycle even though the registers still hold old state.
    assign ostream_val = out_full & ~reset;
    assign ostream_msg = out_msg;
    assign can_accept  = ~out_full | ostream_rdy;
    assign istream_rdy = (can_accept && !reset) ? grant : '0;
    assign xfer_in     = |istream_rdy;
    assign xfer_out    = ostream_val & ostream_rdy;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            out_full <= 1'b0;
            // NOTE: the payload register is reset too, so ostream_msg reads zero after reset.
            out_msg  <= '0;
            ptr      <= '0;
        end else if (xfer_in) begin
            out_full <= 1'b1;
            out_msg  <= {grant_idx, istream_msg[grant_idx]};
            ptr      <= wrap_add(grant_idx, 1);
        end else if (xfer_out) begin
            out_full <= 1'b0;
        end
    end

    assert property (@(posedge clk) disable iff (reset) $onehot0(istream_rdy));

    assert property (@(posedge clk) disable iff (reset)
                     (ostream_val && !ostream_rdy) |=> $stable(ostream_msg));

    assert property (@(posedge clk) disable iff (reset) 32'(ptr) < n_u);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter (nbits=8, ninputs=4): vector table, hand sequences,
// random traffic, with an output scoreboard fed from a small arbitration model.
module tb_rr_stream_arbiter;

    localparam int nbits   = 8;
    localparam int ninputs = 4;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic [ninputs-1:0]           istream_val = '0;
    logic [ninputs-1:0][nbits-1:0] istream_msg = '0;
    logic [ninputs-1:0]           istream_rdy;
    logic                         ostream_val;
    logic [9:0]                   ostream_msg;
    logic                         ostream_rdy = 1'b0;

    rr_stream_arbiter #(.nbits(nbits), .ninputs(ninputs)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_msg (istream_msg),
        .istream_rdy (istream_rdy),
        .ostream_val (ostream_val),
        .ostream_msg (ostream_msg),
        .ostream_rdy (ostream_rdy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [9:0] sb_q[$];
    logic       m_full = 1'b0;
    int         m_ptr  = 0;
    logic [3:0] m_rdy  = '0;

    typedef struct {
        logic        rst;
        logic [3:0]  val;
        logic [31:0] msg;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_oval;
        logic [9:0]  e_omsg;
        logic        chk_msg;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] val, input int p);
        for (int k = 0; k < ninputs; k++) begin
            if (val[(p + k) % ninputs]) return (p + k) % ninputs;
        end
        return -1;
    endfunction

    // One clock cycle: drive after the rising edge, predict, then check on the falling edge.
    task automatic run_cycle(input logic rst, input logic [3:0] val, input logic [31:0] msgs,
                             input logic ordy, input logic chk, input logic [3:0] e_rdy,
                             input logic e_oval, input logic [9:0] e_omsg, input logic chk_msg);
        int         g;
        logic       acc;
        logic [9:0] exp_msg;
        @(posedge clk);
        #1;
        reset       = rst;
        istream_val = val;
        istream_msg = msgs;
        ostream_rdy = ordy;

        g   = model_grant(val, m_ptr);
        acc = !m_full || ordy;
        if (rst) begin
            sb_q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
            m_rdy  = '0;
        end else if (acc && g >= 0) begin
            m_rdy = 4'b0001 << g;
            sb_q.push_back({g[1:0], msgs[g*8 +: 8]});
            m_full = 1'b1;
            m_ptr  = (g + 1) % ninputs;
        end else begin
            m_rdy = '0;
            if (m_full && ordy) m_full = 1'b0;
        end

        @(negedge clk);
        check("rdy_model", 32'(istream_rdy), 32'(m_rdy));
        if (chk) begin
            check("rdy", 32'(istream_rdy), 32'(e_rdy));
            check("oval", 32'(ostream_val), 32'(e_oval));
            if (chk_msg) check("omsg", 32'(ostream_msg), 32'(e_omsg));
        end
        if (ostream_val === 1'b1 && ostream_rdy) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected @%0t: got %0h expected no output", $time, ostream_msg);
            end else begin
                exp_msg = sb_q.pop_front();
                check("sb_msg", 32'(ostream_msg), 32'(exp_msg));
            end
        end
    endtask

    task automatic hand(input logic rst, input logic [3:0] val, input logic [31:0] msgs,
                        input logic ordy, input logic [3:0] e_rdy, input logic e_oval,
                        input logic [9:0] e_omsg);
        run_cycle(rst, val, msgs, ordy, 1'b1, e_rdy, e_oval, e_omsg, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, single requester, all-valid rotation with no bubbles, drain.
        vecs[0]  = '{1'b1, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1};
        vecs[1]  = '{1'b1, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1};
        vecs[2]  = '{1'b0, 4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b0, 10'h000, 1'b1};
        vecs[3]  = '{1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b1, 10'h2A5, 1'b1};
        vecs[4]  = '{1'b1, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 10'h2A5, 1'b1};
        vecs[5]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b0, 10'h000, 1'b1};
        vecs[6]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h2, 1'b1, 10'h010, 1'b1};
        vecs[7]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h4, 1'b1, 10'h111, 1'b1};
        vecs[8]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 10'h212, 1'b1};
        vecs[9]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 10'h313, 1'b1};
        vecs[10] = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h2, 1'b1, 10'h010, 1'b1};
        vecs[11] = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h4, 1'b1, 10'h111, 1'b1};
        vecs[12] = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 10'h212, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b1, 10'h313, 1'b1};
        vecs[14] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 10'h313, 1'b1};

        for (int i = 0; i < 15; i++) begin
            run_cycle(vecs[i].rst, vecs[i].val, vecs[i].msg, vecs[i].ordy, 1'b1,
                      vecs[i].e_rdy, vecs[i].e_oval, vecs[i].e_omsg, vecs[i].chk_msg);
        end

        // Backpressure: fill from input 0, stall 3 cycles with inputs 1 and 3 waiting.
        hand(1'b0, 4'h1, 32'h00000040, 1'b0, 4'h1, 1'b0, 10'h313);
        hand(1'b0, 4'hA, 32'h43004100, 1'b0, 4'h0, 1'b1, 10'h040);
        hand(1'b0, 4'hA, 32'h43004100, 1'b0, 4'h0, 1'b1, 10'h040);
        hand(1'b0, 4'hA, 32'h43004100, 1'b0, 4'h0, 1'b1, 10'h040);
        hand(1'b0, 4'hA, 32'h43004100, 1'b1, 4'h2, 1'b1, 10'h040);
        hand(1'b0, 4'h8, 32'h43000000, 1'b1, 4'h8, 1'b1, 10'h141);
        // All valid right after input 3 won: grant to 0 shows the pointer wrapped.
        hand(1'b0, 4'hF, 32'h53525150, 1'b1, 4'h1, 1'b1, 10'h343);
        // Input 3 wins, then only input 0 is valid and is served next with tag 0.
        hand(1'b0, 4'h8, 32'h63000000, 1'b1, 4'h8, 1'b1, 10'h050);
        hand(1'b0, 4'h1, 32'h00000070, 1'b1, 4'h1, 1'b1, 10'h363);
        hand(1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b1, 10'h070);
        // Reset while a message is held and stalled: it must be dropped, pointer back to 0.
        hand(1'b0, 4'h4, 32'h00800000, 1'b0, 4'h4, 1'b0, 10'h070);
        hand(1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b1, 10'h280);
        hand(1'b1, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 10'h280);
        hand(1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 10'h000);
        hand(1'b0, 4'hF, 32'h93929190, 1'b1, 4'h1, 1'b0, 10'h000);
        hand(1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b1, 10'h090);
        hand(1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 10'h090);

        // Random traffic, checked by the model and the output scoreboard.
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom_range(49) == 0), 4'($urandom), $urandom,
                      ($urandom_range(3) != 0), 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
